// File: rtl/e_strobe_uart_tx_if.sv
//------------------------------------------------------------------------------
// Module   : e_strobe_uart_tx_if
// Purpose  : 8X305 output-port strobe bus plus UART status/serial signals.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface e_strobe_uart_tx_if;
  logic [7:0] data_in;
  logic       rs;
  logic       ceb;
  logic       e;
  logic       txd;
  logic       busy;
  logic       fifo_full;
  logic       overrun;
  logic [7:0] cmd;

  modport master (
    output data_in, rs, ceb, e,
    input  txd, busy, fifo_full, overrun, cmd
  );

  modport slave (
    input  data_in, rs, ceb, e,
    output txd, busy, fifo_full, overrun, cmd
  );
endinterface

`default_nettype wire

// File: rtl/e_strobe_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : e_strobe_uart_tx
// Purpose  : E-strobe driven UART transmitter with data FIFO for the 8X305 bus.
//            Optional even-parity frames: define UART_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module e_strobe_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  e_strobe_uart_tx_if.slave cpu_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_e;

  // e is asynchronous to clk: two-flop synchronizer, edge detect, registered pulse
  logic e_meta_q, e_sync_q, e_prev_q, wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_meta_q <= 1'b0;
      e_sync_q <= 1'b0;
      e_prev_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      e_meta_q <= cpu_if.e;
      e_sync_q <= e_meta_q;
      e_prev_q <= e_sync_q;
      wr_q     <= e_sync_q & ~e_prev_q;
    end
  end

  logic wr_cmd, wr_data, master_rst;
  assign wr_cmd     = wr_q & ~cpu_if.ceb & cpu_if.rs;
  assign wr_data    = wr_q & ~cpu_if.ceb & ~cpu_if.rs;
  assign master_rst = wr_cmd & (cpu_if.data_in[1:0] == 2'b11);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    cmd_q;
  logic          overrun_q;
  logic          pop, empty, full, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign push_ok = wr_data & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= cpu_if.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      cmd_q     <= 8'h00;
    end else if (master_rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      cmd_q     <= {cpu_if.data_in[7:2], 2'b00};
    end else begin
      if (wr_cmd)             cmd_q     <= cpu_if.data_in;
      if (push_ok)            wptr_q    <= wptr_q + 1'b1;
      if (pop)                rptr_q    <= rptr_q + 1'b1;
      if (wr_data && !push_ok) overrun_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          load, bit_end;
`ifdef UART_PARITY_EN
  logic          par_en_q, par_en_d, par_bit_q, par_bit_d;
`endif

  assign bit_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= 3'd0;
      sh_q      <= 8'h00;
      txd_q     <= 1'b1;
`ifdef UART_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      txd_q     <= txd_d;
`ifdef UART_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // txd_d is the line level for the state being entered, so txd stays registered
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    txd_d     = txd_q;
    load      = 1'b0;
    pop       = 1'b0;
`ifdef UART_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      S_START: begin
        div_d = div_q + 1'b1;
        if (bit_end) begin
          div_d   = '0;
          state_d = S_DATA;
          txd_d   = sh_q[0];
        end
      end
      S_DATA: begin
        div_d = div_q + 1'b1;
        if (bit_end) begin
          div_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
            txd_d   = par_en_q ? par_bit_q : 1'b1;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        div_d = div_q + 1'b1;
        if (bit_end) begin
          div_d   = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        div_d = div_q + 1'b1;
        if (bit_end) begin
          div_d = '0;
          if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (load) begin
      pop       = 1'b1;
      sh_d      = mem_q[rptr_q];
      state_d   = S_START;
      txd_d     = 1'b0;
      div_d     = '0;
      bit_d     = 3'd0;
`ifdef UART_PARITY_EN
      par_en_d  = cmd_q[2];
      par_bit_d = ^mem_q[rptr_q];
`endif
    end

    if (master_rst) begin
      pop     = 1'b0;
      state_d = S_IDLE;
      txd_d   = 1'b1;
      div_d   = '0;
      bit_d   = 3'd0;
    end
  end

  assign cpu_if.txd       = txd_q;
  assign cpu_if.busy      = (state_q != S_IDLE) | ~empty;
  assign cpu_if.fifo_full = full;
  assign cpu_if.overrun   = overrun_q;
  assign cpu_if.cmd       = cmd_q;

endmodule

`default_nettype wire

// File: tb/tb_e_strobe_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_e_strobe_uart_tx
// Purpose  : Self-checking bench for e_strobe_uart_tx (honours UART_PARITY_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_e_strobe_uart_tx;
  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int S_TXD = 0, S_BUSY = 1, S_FULL = 2, S_OVR = 3, S_CMD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  e_strobe_uart_tx_if bus();

  e_strobe_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .cpu_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic rs; logic ceb; logic [7:0] d; } wr_t;
  typedef struct { int cyc; int sig; logic [7:0] val; string nm; } ex_t;

  wr_t wq [64];
  int  wq_n = 0;
  int  wq_rd = 0;
  ex_t xq [128];
  int  xq_n = 0;
  int  xq_rd = 0;
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  // Model: FIFO of bytes and a queue of per-clock line levels for the frame in flight
  logic [7:0] fifo_m [$];
  logic       line_m [$];
  logic [7:0] cmd_m = 8'h00;
  logic       ovr_m = 1'b0, txd_m = 1'b1, busy_m = 1'b0, full_m = 1'b0;

  task automatic load_frame(input logic [7:0] b, input logic par);
    for (int i = 0; i < CD; i++) line_m.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < CD; i++) line_m.push_back(b[j]);
    if (par)
      for (int i = 0; i < CD; i++) line_m.push_back(^b);
    for (int i = 0; i < CD; i++) line_m.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    logic in_frame;
    logic par;
    wr_t  w;
    cyc = cyc + 1;
    if (rst) begin
      fifo_m.delete();
      line_m.delete();
      cmd_m  = 8'h00;
      ovr_m  = 1'b0;
      txd_m  = 1'b1;
      busy_m = 1'b0;
      full_m = 1'b0;
      wq_rd  = wq_n;
    end else begin
      in_frame = 1'b0;
      if (line_m.size() == 0 && fifo_m.size() != 0) begin
`ifdef UART_PARITY_EN
        par = cmd_m[2];
`else
        par = 1'b0;
`endif
        load_frame(fifo_m.pop_front(), par);
      end
      if (line_m.size() != 0) begin
        txd_m    = line_m.pop_front();
        in_frame = 1'b1;
      end else begin
        txd_m = 1'b1;
      end
      while (wq_rd < wq_n && wq[wq_rd].cyc <= cyc) begin
        w = wq[wq_rd];
        wq_rd++;
        if (w.cyc == cyc && !w.ceb) begin
          if (w.rs) begin
            if (w.d[1:0] == 2'b11) begin
              fifo_m.delete();
              line_m.delete();
              ovr_m    = 1'b0;
              txd_m    = 1'b1;
              in_frame = 1'b0;
              cmd_m    = {w.d[7:2], 2'b00};
            end else begin
              cmd_m = w.d;
            end
          end else if (fifo_m.size() < DEPTH) begin
            fifo_m.push_back(w.d);
          end else begin
            ovr_m = 1'b1;
          end
        end
      end
      busy_m = in_frame || (fifo_m.size() != 0);
      full_m = (fifo_m.size() == DEPTH);
    end
  end

  function automatic logic [7:0] sigval(input int s);
    case (s)
      S_TXD:   return {7'b0, bus.txd};
      S_BUSY:  return {7'b0, bus.busy};
      S_FULL:  return {7'b0, bus.fifo_full};
      S_OVR:   return {7'b0, bus.overrun};
      default: return bus.cmd;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_txd",  sigval(S_TXD),  8'h01);
      chk("rst_busy", sigval(S_BUSY), 8'h00);
      chk("rst_full", sigval(S_FULL), 8'h00);
      chk("rst_ovr",  sigval(S_OVR),  8'h00);
      chk("rst_cmd",  sigval(S_CMD),  8'h00);
    end else begin
      chk("txd",       sigval(S_TXD),  {7'b0, txd_m});
      chk("busy",      sigval(S_BUSY), {7'b0, busy_m});
      chk("fifo_full", sigval(S_FULL), {7'b0, full_m});
      chk("overrun",   sigval(S_OVR),  {7'b0, ovr_m});
      chk("cmd",       sigval(S_CMD),  cmd_m);
      while (xq_rd < xq_n && xq[xq_rd].cyc <= cyc) begin
        if (xq[xq_rd].cyc == cyc) begin
          chk(xq[xq_rd].nm, sigval(xq[xq_rd].sig), xq[xq_rd].val);
        end else begin
          checks++;
          failures++;
          $display("FAIL %s cyc=%0d actual=unsampled required=%0h", xq[xq_rd].nm, xq[xq_rd].cyc, xq[xq_rd].val);
        end
        xq_rd++;
      end
    end
  end

  task automatic expect_at(input int c, input int s, input logic [7:0] v, input string nm);
    xq[xq_n] = '{cyc: c, sig: s, val: v, nm: nm};
    xq_n++;
  endtask

  // Raises e just after an edge; the byte takes effect 4 edges later
  task automatic start_write(input logic rs, input logic ceb, input logic [7:0] d, output int k);
    @(posedge clk);
    #2;
    bus.data_in = d;
    bus.rs      = rs;
    bus.ceb     = ceb;
    bus.e       = 1'b1;
    k           = cyc;
    wq[wq_n]    = '{cyc: k + 4, rs: rs, ceb: ceb, d: d};
    wq_n++;
  endtask

  task automatic finish_write(input int hi, input int lo);
    repeat (hi) @(posedge clk);
    #2 bus.e = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  initial begin
    int k, k0;
    logic [9:0] pat;
    bus.e       = 1'b0;
    bus.ceb     = 1'b1;
    bus.rs      = 1'b0;
    bus.data_in = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Basic byte: latency, bit pattern, frame length
    start_write(1'b0, 1'b0, 8'h41, k);
    expect_at(k + 4, S_TXD, 8'h01, "lat_idle");
    expect_at(k + 5, S_TXD, 8'h00, "lat_start");
    pat = {1'b1, 8'h41, 1'b0};
    for (int j = 0; j < 10; j++) expect_at(k + 7 + 4 * j, S_TXD, {7'b0, pat[j]}, "bit41");
    expect_at(k + 44, S_BUSY, 8'h01, "busy_last");
    expect_at(k + 45, S_BUSY, 8'h00, "busy_done");
    finish_write(6, 2);
    repeat (50) @(posedge clk);

    // FIFO overrun: six writes four clocks apart
    for (int i = 0; i < 6; i++) begin
      start_write(1'b0, 1'b0, 8'h30 + 8'(i), k);
      if (i == 0) begin
        k0 = k;
        expect_at(k0 + 20, S_FULL, 8'h01, "full_hit");
        expect_at(k0 + 23, S_OVR,  8'h00, "ovr_before");
        expect_at(k0 + 24, S_OVR,  8'h01, "ovr_set");
        expect_at(k0 + 51, S_TXD,  8'h01, "b2b_bit0");
      end
      finish_write(2, 1);
    end
    repeat (260) @(posedge clk);

    // Master reset during DATA (lands in bit1 = 0 of 8'h55)
    start_write(1'b0, 1'b0, 8'h55, k);
    finish_write(6, 2);
    repeat (2) @(posedge clk);
    start_write(1'b1, 1'b0, 8'h03, k);
    expect_at(k + 3, S_TXD,  8'h00, "mr_pre_txd");
    expect_at(k + 3, S_OVR,  8'h01, "mr_pre_ovr");
    expect_at(k + 4, S_TXD,  8'h01, "mr_txd");
    expect_at(k + 4, S_BUSY, 8'h00, "mr_busy");
    expect_at(k + 4, S_OVR,  8'h00, "mr_ovr");
    expect_at(k + 4, S_CMD,  8'h00, "mr_cmd");
    expect_at(k + 12, S_TXD, 8'h01, "mr_quiet");
    finish_write(6, 2);
    repeat (60) @(posedge clk);

    // Parity enable command, then 8'h07 and 8'h03
    start_write(1'b1, 1'b0, 8'h04, k);
    finish_write(6, 2);
    start_write(1'b0, 1'b0, 8'h07, k);
    expect_at(k + 5, S_CMD, 8'h04, "par_cmd");
    expect_at(k + 43, S_TXD, 8'h01, "par07_bit");
`ifdef UART_PARITY_EN
    expect_at(k + 48, S_BUSY, 8'h01, "len44_last");
    expect_at(k + 49, S_BUSY, 8'h00, "len44_done");
`else
    expect_at(k + 44, S_BUSY, 8'h01, "len40_last");
    expect_at(k + 45, S_BUSY, 8'h00, "len40_done");
`endif
    finish_write(6, 2);
    repeat (60) @(posedge clk);
    start_write(1'b0, 1'b0, 8'h03, k);
`ifdef UART_PARITY_EN
    expect_at(k + 43, S_TXD, 8'h00, "par03_bit");
`else
    expect_at(k + 43, S_TXD, 8'h01, "par03_stop");
`endif
    finish_write(6, 2);
    repeat (60) @(posedge clk);

    // Strobe gating: ceb high ignored; long e gives one write
    start_write(1'b0, 1'b1, 8'hAA, k);
    expect_at(k + 5, S_TXD,  8'h01, "ceb_txd");
    expect_at(k + 6, S_BUSY, 8'h00, "ceb_busy");
    expect_at(k + 6, S_CMD,  8'h04, "ceb_cmd");
    finish_write(6, 2);
    repeat (10) @(posedge clk);
    start_write(1'b0, 1'b0, 8'h5A, k);
    expect_at(k + 5, S_TXD,  8'h00, "hold_start");
    expect_at(k + 55, S_BUSY, 8'h00, "hold_once");
    finish_write(20, 2);
    repeat (80) @(posedge clk);

    // Asynchronous reset mid-frame, then a clean transmission
    start_write(1'b1, 1'b0, 8'h80, k);
    finish_write(6, 2);
    start_write(1'b0, 1'b0, 8'h3C, k);
    finish_write(6, 2);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    start_write(1'b0, 1'b0, 8'h41, k);
    expect_at(k + 4, S_TXD, 8'h01, "post_rst_idle");
    expect_at(k + 5, S_TXD, 8'h00, "post_rst_start");
    expect_at(k + 5, S_CMD, 8'h00, "post_rst_cmd");
    finish_write(6, 2);
    repeat (60) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e_strobe_uart_tx.md
Name: e_strobe_uart_tx

Overview:
Bus-side UART transmitter that answers the 8X305 computer's output-port peripheral strobes (RS, UART_CEb, E, 8-bit data latch) and serializes written bytes onto an asynchronous TX line.
- Sits behind output_port / output_port2_latch.
- A rising E with CEb low is a CPU write: RS=1 writes the command register, RS=0 queues a data byte.
- A small FIFO decouples CPU writes from the bit-rate shifter.

Parameters:
CLK_DIV, 16, clk cycles per serial bit (>=2)
FIFO_DEPTH, 4, data FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
data_in  input  8  byte from the CPU data latch, stable while e is high
rs  input  1  register select: 1=command, 0=data
ceb  input  1  chip enable, active low
e  input  1  write strobe, asynchronous to clk, active on rising edge
txd  output  1  serial out, idle high
busy  output  1  frame in progress or FIFO non-empty
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
overrun  output  1  sticky: a data write was dropped because the FIFO was full
cmd  output  8  current command register

Behaviour:
Reset and strobe detection
- Reset, asynchronous and applied immediately: txd=1, busy=0, fifo_full=0, overrun=0, cmd=8'h00, FIFO empty, shifter IDLE, synchronizers cleared.
- e passes through a 2-flop synchronizer; rising-edge detect on the synchronized value gives a one-cycle wr pulse 3 clk edges after e rises.
- On wr, ceb and rs are sampled directly; they must be stable while e is high.
- wr with ceb=1 is ignored.

Command writes (wr, ceb=0, rs=1)
- If data_in[1:0]==2'b11 (master reset): FIFO flushed, overrun cleared, shifter aborted to IDLE, txd=1 on the next clk, cmd <= {data_in[7:2],2'b00}.
- Otherwise cmd <= data_in.
- cmd[2] is parity enable (even parity); see the optional feature.

Data writes (wr, ceb=0, rs=0)
- data_in is pushed to the FIFO.
- If the FIFO is full and no pop happens in the same cycle, the byte is dropped and overrun is set.
- Push and pop in the same cycle while full: the write is accepted and count is unchanged.

Shifter FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
- IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register and enter START on the next clk.
- START: txd=0 for CLK_DIV cycles.
- DATA: 8 bits LSB first, CLK_DIV cycles each; a 3-bit bit counter wraps 7->0 on exit.
- PARITY: only when parity is active; txd = XOR of the 8 data bits (even parity).
- STOP: txd=1 for CLK_DIV cycles, then IDLE.
- Back-to-back frames: when the FIFO is non-empty at the end of STOP, the next pop happens in that same cycle and START follows immediately, with no extra idle cycle.
- Parity mode is latched at pop time. A cmd change mid-frame affects only later frames.

Timing and outputs
- Frame length: 10*CLK_DIV clocks, or 11*CLK_DIV with parity.
- Latency: e rising edge to txd falling edge is 5 clk when the block is idle and the FIFO is empty.
- busy = (state!=IDLE) | FIFO non-empty.
- All outputs are registered except busy and fifo_full, which are decoded from registers.

Optional Feature:
UART_PARITY_EN
- Defined: cmd[2]=1 inserts the PARITY state, giving 11-bit frames.
- Undefined: cmd[2] is stored but ignored, the PARITY state and parity logic are not built, and frames are always 10 bits.

Test Plan:
- Basic byte (CLK_DIV=4): after reset, write rs=0 data 8'h41 -> txd low at 5 clk. Bits sampled mid-bit read 0,1,0,0,0,0,0,1,0 then stop 1. busy deasserts 40 clk after start.
- FIFO overrun (FIFO_DEPTH=4): write 6 bytes 8'h30..8'h35 spaced 4 clk apart during the first frame -> 8'h30..8'h34 transmitted in order, 8'h35 dropped, overrun=1, fifo_full seen high.
- Master reset mid-frame: during DATA of 8'h55, write rs=1 data 8'h03 -> txd=1 on the next clk, busy=0, overrun cleared, cmd=8'h00, no further bits emitted.
- Parity (UART_PARITY_EN): cmd=8'h04, send 8'h07 -> parity bit 1, frame 44 clk. Send 8'h03 -> parity bit 0. Without the macro, both frames are 40 clk with no parity bit.
- Strobe gating: e pulse with ceb=1 carrying 8'hAA -> txd stays 1, FIFO empty, cmd unchanged. e held high for 20 clk -> exactly one write.
- Async reset mid-frame: assert rst between clk edges during a frame -> txd=1 and cmd=8'h00 immediately. After release, the first new write transmits normally.
